// File: rtl/mar_burst_ctrl.sv
// ---------------------------------------------------------------------------
// mar_burst_ctrl
//
// Memory address register with a single-step incrementer and a handshaked
// multi-beat burst address generator. The MAR is loaded from the MBR or the
// PC, stepped by STRIDE on request, or swept across a block of addresses in
// BURST mode while the memory interface accepts one beat per i_mem_ready.
//
// Parameters
//   ADDR_W : address width in bits
//   LEN_W  : burst length field width (max burst 2^LEN_W-1 beats)
//   STRIDE : address increment per step or beat (1 .. 2^ADDR_W-1)
//
// Ports
//   i_clk              : clock, rising edge
//   i_rst_n            : asynchronous active-low reset
//   i_mbr_mar          : load value from MBR
//   i_pc_mar           : load value from PC
//   ctrl_load_mbr      : load MAR from i_mbr_mar (IDLE only)
//   ctrl_load_pc       : load MAR from i_pc_mar (IDLE only)
//   ctrl_mar_increment : MAR += STRIDE (IDLE only)
//   ctrl_burst_start   : begin a burst at the current MAR (IDLE only)
//   i_burst_len        : beat count, sampled with ctrl_burst_start
//   ctrl_burst_abort   : end the burst immediately, no done pulse
//   i_mem_ready        : memory accepted the current beat address
//   o_mar_address_bus  : current MAR value
//   o_addr_valid       : burst beat address valid
//   o_burst_busy       : controller is in BURST
//   o_burst_done       : one-cycle pulse after the last beat is accepted
//   o_wrap             : one-cycle pulse when an increment carried out
// ---------------------------------------------------------------------------
module mar_burst_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4,
    parameter int STRIDE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_mbr_mar,
    input  logic [ADDR_W-1:0] i_pc_mar,
    input  logic              ctrl_load_mbr,
    input  logic              ctrl_load_pc,
    input  logic              ctrl_mar_increment,
    input  logic              ctrl_burst_start,
    input  logic [LEN_W-1:0]  i_burst_len,
    input  logic              ctrl_burst_abort,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mar_address_bus,
    output logic              o_addr_valid,
    output logic              o_burst_busy,
    output logic              o_burst_done,
    output logic              o_wrap
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] STRIDE_V = ADDR_W'(STRIDE);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;

    // One extra bit on the adder exposes the carry out of ADDR_W; the low
    // bits are the modulo-2^ADDR_W result.
    logic [ADDR_W:0]   mar_sum;
    logic [ADDR_W-1:0] mar_inc;
    logic              mar_carry;

    assign mar_sum   = {1'b0, mar_q} + {1'b0, STRIDE_V};
    assign mar_inc   = mar_sum[ADDR_W-1:0];
    assign mar_carry = mar_sum[ADDR_W];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            mar_q       <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A zero-length start request falls through to the
                // remaining IDLE controls as if it were never asserted.
                if (ctrl_burst_start && (i_burst_len != LEN_ZERO)) begin
                    state_d     = BURST;
                    remaining_d = i_burst_len;
                end else if (ctrl_load_mbr) begin
                    mar_d = i_mbr_mar;
                end else if (ctrl_load_pc) begin
                    mar_d = i_pc_mar;
                end else if (ctrl_mar_increment) begin
                    mar_d  = mar_inc;
                    wrap_d = mar_carry;
                end
            end

            BURST: begin
                // Abort outranks the handshake; no done pulse is produced.
                if (ctrl_burst_abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (i_mem_ready) begin
                    if (remaining_q > LEN_ONE) begin
                        mar_d       = mar_inc;
                        wrap_d      = mar_carry;
                        remaining_d = remaining_q - LEN_ONE;
                    end else begin
                        // Last beat accepted: MAR keeps the final beat address.
                        state_d     = IDLE;
                        remaining_d = '0;
                        done_d      = 1'b1;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: pure decodes of registered state, never of inputs
    // -----------------------------------------------------------------------
    always_comb begin
        o_mar_address_bus = mar_q;
        o_burst_busy      = (state_q == BURST);
        o_addr_valid      = (state_q == BURST);
        o_burst_done      = done_q;
        o_wrap            = wrap_q;
    end

endmodule
